// File: rtl/i2c_slave_edid_responder.sv
// I2C slave that matches one device address, takes a word-address pointer and write bytes,
// and streams sequential reads from an external 256-byte memory with 1-clk read latency.
module i2c_slave_edid_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_sclk_IN,
    input  logic       i2c_sdat_IN,
    output logic       i2c_sdat_OUT,
    output logic       i2c_sdat_OE,
    output logic       mem_rd_en,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic       mem_wr_en,
    output logic [7:0] mem_wdata,
    output logic       busy
);

    localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        WORD_ADDR,
        WORD_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
    } state_t;

    // Bit 0 carries SCL, bit 1 carries SDA through identical sync/filter paths.
    logic [1:0] pad_in;
    logic [1:0] filt;
    logic [1:0] filt_prev_reg;

    assign pad_in = {i2c_sdat_IN, i2c_sclk_IN};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic       sync1_reg;
            logic       sync2_reg;
            logic       filt_reg;
            logic [3:0] cnt_reg;

            // Reset to the idle-high bus level so leaving reset never fakes an edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    filt_reg  <= 1'b1;
                    cnt_reg   <= 4'd0;
                end else begin
                    sync1_reg <= pad_in[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg != filt_reg) begin
                        if (cnt_reg == CNT_MAX) begin
                            filt_reg <= sync2_reg;
                            cnt_reg  <= 4'd0;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end else begin
                        cnt_reg <= 4'd0;
                    end
                end
            end

            assign filt[gi] = filt_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_prev_reg <= 2'b11;
        end else begin
            filt_prev_reg <= filt;
        end
    end

    logic scl, sda, scl_prev, sda_prev;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl       = filt[0];
    assign sda       = filt[1];
    assign scl_prev  = filt_prev_reg[0];
    assign sda_prev  = filt_prev_reg[1];
    assign scl_rise  = scl & ~scl_prev;
    assign scl_fall  = ~scl & scl_prev;
    assign start_det = scl & scl_prev & sda_prev & ~sda;
    assign stop_det  = scl & scl_prev & ~sda_prev & sda;

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic       rw_reg, rw_next;
    logic       oe_reg, oe_next;
    logic [7:0] ptr_reg, ptr_next;
    logic       rd_en_reg, rd_en_next;
    logic       rd_pend_reg, rd_pend_next;
    logic       rd_req_reg, rd_req_next;
    logic       ptr_inc_reg, ptr_inc_next;
    logic       wr_en_reg, wr_en_next;
    logic [7:0] wdata_reg, wdata_next;
    logic       busy_reg, busy_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= 3'd0;
            shift_reg   <= 8'd0;
            rw_reg      <= 1'b0;
            oe_reg      <= 1'b0;
            ptr_reg     <= 8'd0;
            rd_en_reg   <= 1'b0;
            rd_pend_reg <= 1'b0;
            rd_req_reg  <= 1'b0;
            ptr_inc_reg <= 1'b0;
            wr_en_reg   <= 1'b0;
            wdata_reg   <= 8'd0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            shift_reg   <= shift_next;
            rw_reg      <= rw_next;
            oe_reg      <= oe_next;
            ptr_reg     <= ptr_next;
            rd_en_reg   <= rd_en_next;
            rd_pend_reg <= rd_pend_next;
            rd_req_reg  <= rd_req_next;
            ptr_inc_reg <= ptr_inc_next;
            wr_en_reg   <= wr_en_next;
            wdata_reg   <= wdata_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        shift_next   = shift_reg;
        rw_next      = rw_reg;
        oe_next      = oe_reg;
        ptr_next     = ptr_reg;
        rd_en_next   = rd_req_reg;
        rd_pend_next = rd_en_reg;
        rd_req_next  = 1'b0;
        ptr_inc_next = 1'b0;
        wr_en_next   = 1'b0;
        wdata_next   = wdata_reg;
        busy_next    = busy_reg;

        // Read data lands one clk after the strobe; pointer steps one clk after a write or read ACK.
        if (rd_pend_reg) shift_next = mem_rdata;
        if (wr_en_reg || ptr_inc_reg) ptr_next = ptr_reg + 8'd1;

        case (state_reg)
            IDLE: ;
            DEV_ADDR: begin
                if (scl_rise) begin
                    shift_next = {shift_reg[6:0], sda};
                    cnt_next   = cnt_reg + 3'd1;
                    if (cnt_reg == 3'd7) begin
                        if (shift_reg[6:0] == SLAVE_ADDR) begin
                            state_next = DEV_ACK;
                            rw_next    = sda;
                            rd_en_next = sda;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            // In the ACK states the first fall asserts OE and the second one ends the ACK slot.
            DEV_ACK: begin
                if (scl_fall) begin
                    if (!oe_reg) begin
                        oe_next = 1'b1;
                    end else if (rw_reg) begin
                        state_next = RD_DATA;
                        oe_next    = ~shift_reg[7];
                        cnt_next   = 3'd0;
                    end else begin
                        state_next = WORD_ADDR;
                        oe_next    = 1'b0;
                        cnt_next   = 3'd0;
                    end
                end
            end
            WORD_ADDR: begin
                if (scl_rise) begin
                    shift_next = {shift_reg[6:0], sda};
                    cnt_next   = cnt_reg + 3'd1;
                    if (cnt_reg == 3'd7) state_next = WORD_ACK;
                end
            end
            WORD_ACK: begin
                if (scl_fall) begin
                    if (!oe_reg) begin
                        oe_next = 1'b1;
                    end else begin
                        oe_next    = 1'b0;
                        ptr_next   = shift_reg;
                        state_next = WR_DATA;
                        cnt_next   = 3'd0;
                    end
                end
            end
            WR_DATA: begin
                if (scl_rise) begin
                    shift_next = {shift_reg[6:0], sda};
                    cnt_next   = cnt_reg + 3'd1;
                    if (cnt_reg == 3'd7) begin
                        state_next = WR_ACK;
                        wr_en_next = 1'b1;
                        wdata_next = {shift_reg[6:0], sda};
                    end
                end
            end
            WR_ACK: begin
                if (scl_fall) begin
                    if (!oe_reg) begin
                        oe_next = 1'b1;
                    end else begin
                        oe_next    = 1'b0;
                        state_next = WR_DATA;
                        cnt_next   = 3'd0;
                    end
                end
            end
            RD_DATA: begin
                if (scl_fall) begin
                    if (cnt_reg == 3'd7) begin
                        oe_next    = 1'b0;
                        state_next = RD_ACK;
                        cnt_next   = 3'd0;
                    end else begin
                        oe_next    = ~shift_reg[6];
                        shift_next = {shift_reg[6:0], 1'b0};
                        cnt_next   = cnt_reg + 3'd1;
                    end
                end
            end
            // cnt_reg==1 marks that the master ACKed and the next byte is being fetched.
            RD_ACK: begin
                if (scl_rise && cnt_reg == 3'd0) begin
                    if (!sda) begin
                        ptr_inc_next = 1'b1;
                        rd_req_next  = 1'b1;
                        cnt_next     = 3'd1;
                    end else begin
                        state_next = IDLE;
                        oe_next    = 1'b0;
                    end
                end else if (scl_fall && cnt_reg == 3'd1) begin
                    state_next = RD_DATA;
                    oe_next    = ~shift_reg[7];
                    cnt_next   = 3'd0;
                end
            end
            default: state_next = IDLE;
        endcase

        if (start_det) begin
            state_next = DEV_ADDR;
            cnt_next   = 3'd0;
            oe_next    = 1'b0;
            busy_next  = 1'b1;
        end
        if (stop_det) begin
            state_next = IDLE;
            oe_next    = 1'b0;
            busy_next  = 1'b0;
        end
    end

    assign i2c_sdat_OUT = 1'b0;
    assign i2c_sdat_OE  = oe_reg;
    assign mem_rd_en    = rd_en_reg;
    assign mem_addr     = ptr_reg;
    assign mem_wr_en    = wr_en_reg;
    assign mem_wdata    = wdata_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_i2c_slave_edid_responder.sv
// Randomized bench: a bit-banged I2C master drives the responder, memory strobes are scored
// against a queue filled by a pointer/memory reference model, read bytes against that model.
module tb_i2c_slave_edid_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       sdat_out, oe;
    logic       mem_rd_en, mem_wr_en, busy;
    logic [7:0] mem_addr, mem_rdata, mem_wdata;
    logic       sda_line;

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~oe;

    i2c_slave_edid_responder #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
        .clk(clk),
        .rst(rst),
        .i2c_sclk_IN(scl_m),
        .i2c_sdat_IN(sda_line),
        .i2c_sdat_OUT(sdat_out),
        .i2c_sdat_OE(oe),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata),
        .busy(busy)
    );

    logic [7:0] tb_mem [256];
    logic [7:0] ref_mem [256];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= tb_mem[mem_addr];
        if (mem_wr_en) tb_mem[mem_addr] <= mem_wdata;
    end

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } strobe_t;

    strobe_t exp_q[$];
    strobe_t exp_s;
    int      n_tests = 0;
    int      n_fail  = 0;
    int      ptr_m   = 0;
    logic    oe_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every memory strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (oe) oe_seen = 1'b1;
        if (mem_wr_en || mem_rd_en) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got wr=%0b rd=%0b addr=%0h, required no strobe",
                         mem_wr_en, mem_rd_en, mem_addr);
            end else begin
                exp_s = exp_q.pop_front();
                chk("strobe_is_write", 32'(mem_wr_en), 32'(exp_s.wr));
                chk("strobe_addr", 32'(mem_addr), 32'(exp_s.addr));
                if (exp_s.wr) chk("strobe_wdata", 32'(mem_wdata), 32'(exp_s.data));
                $display("[TB] strobe %s addr=%02h data=%02h", exp_s.wr ? "WR" : "RD",
                         mem_addr, mem_wdata);
            end
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic drv, output logic smp);
        scl_m = 1'b0; wclk(8);
        sda_m = drv;  wclk(8);
        scl_m = 1'b1; wclk(8);
        smp = sda_line; wclk(8);
    endtask

    task automatic i2c_start();
        scl_m = 1'b0; wclk(8);
        sda_m = 1'b1; wclk(8);
        scl_m = 1'b1; wclk(8);
        sda_m = 1'b0; wclk(8);
    endtask

    task automatic i2c_stop();
        scl_m = 1'b0; wclk(8);
        sda_m = 1'b0; wclk(8);
        scl_m = 1'b1; wclk(8);
        sda_m = 1'b1; wclk(8);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        bit_cycle(1'b1, ack);
    endtask

    task automatic end_checks();
        chk("ptr_after_txn", 32'(mem_addr), 32'(ptr_m));
        chk("busy_after_stop", 32'(busy), 32'd0);
        chk("oe_after_stop", 32'(oe), 32'd0);
    endtask

    task automatic read_bytes(input int n);
        logic [7:0] b;
        logic       s;
        for (int k = 0; k < n; k++) begin
            for (int i = 7; i >= 0; i--) bit_cycle(1'b1, b[i]);
            chk("read_byte", 32'(b), 32'(ref_mem[ptr_m]));
            $display("[TB] read addr=%02h data=%02h", ptr_m[7:0], b);
            if (k < n - 1) begin
                ptr_m = (ptr_m + 1) % 256;
                exp_q.push_back('{wr: 1'b0, addr: 8'(ptr_m), data: 8'h00});
                bit_cycle(1'b0, s);
            end else begin
                bit_cycle(1'b1, s);
                chk("oe_after_nack", 32'(oe), 32'd0);
            end
        end
    endtask

    task automatic txn_write(input logic [7:0] word, input logic [7:0] data [4], input int n);
        logic a;
        i2c_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        send_byte(8'hA0, a); chk("dev_ack_w", 32'(a), 32'd0);
        send_byte(word, a);  chk("word_ack", 32'(a), 32'd0);
        ptr_m = int'(word);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{wr: 1'b1, addr: 8'(ptr_m), data: data[i]});
            send_byte(data[i], a); chk("data_ack", 32'(a), 32'd0);
            ref_mem[ptr_m] = data[i];
            ptr_m = (ptr_m + 1) % 256;
        end
        i2c_stop();
        end_checks();
        $display("[TB] write word=%02h n=%0d ptr_end=%02h", word, n, ptr_m[7:0]);
    endtask

    task automatic txn_random_read(input logic [7:0] word, input int n);
        logic a;
        i2c_start();
        send_byte(8'hA0, a); chk("dev_ack_w", 32'(a), 32'd0);
        send_byte(word, a);  chk("word_ack", 32'(a), 32'd0);
        ptr_m = int'(word);
        i2c_start();
        exp_q.push_back('{wr: 1'b0, addr: 8'(ptr_m), data: 8'h00});
        send_byte(8'hA1, a); chk("dev_ack_r", 32'(a), 32'd0);
        read_bytes(n);
        i2c_stop();
        end_checks();
        $display("[TB] random read word=%02h n=%0d", word, n);
    endtask

    task automatic txn_current_read(input int n);
        logic a;
        i2c_start();
        exp_q.push_back('{wr: 1'b0, addr: 8'(ptr_m), data: 8'h00});
        send_byte(8'hA1, a); chk("dev_ack_r", 32'(a), 32'd0);
        read_bytes(n);
        i2c_stop();
        end_checks();
        $display("[TB] current read n=%0d", n);
    endtask

    task automatic txn_mismatch(input logic [7:0] dev);
        logic a;
        oe_seen = 1'b0;
        i2c_start();
        send_byte(dev, a); chk("dev_nack", 32'(a), 32'd1);
        for (int i = 0; i < 2; i++) begin
            send_byte(8'($urandom), a); chk("mismatch_byte_nack", 32'(a), 32'd1);
        end
        i2c_stop();
        chk("mismatch_oe_quiet", 32'(oe_seen), 32'd0);
        end_checks();
        $display("[TB] mismatch dev=%02h", dev);
    endtask

    initial begin
        #3ms;
        $display("FAIL timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d [4];
        logic [7:0] dev;
        logic       a, s;
        int         sel, n;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            tb_mem[i]  = ref_mem[i];
        end
        wclk(5);
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_out", 32'(sdat_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_strobes", 32'({mem_rd_en, mem_wr_en}), 32'd0);
        rst = 1'b0;
        wclk(10);

        d = '{8'h12, 8'h34, 8'h00, 8'h00};
        txn_write(8'h00, d, 2);
        txn_random_read(8'h10, 3);
        txn_mismatch(8'hA2);
        txn_random_read(8'hFE, 4);

        // A 2-clk SDA dip with SCL high is shorter than the filter and must not start a transfer.
        wclk(10);
        sda_m = 1'b0; wclk(2); sda_m = 1'b1; wclk(20);
        chk("glitch_no_start", 32'(busy), 32'd0);
        $display("[TB] glitch busy=%0b", busy);

        // Reset in the middle of the 4th bit of a read byte whose bits are all zero.
        d = '{8'h00, 8'h00, 8'h00, 8'h00};
        txn_write(8'h40, d, 1);
        i2c_start();
        send_byte(8'hA0, a); chk("dev_ack_w", 32'(a), 32'd0);
        send_byte(8'h40, a); chk("word_ack", 32'(a), 32'd0);
        ptr_m = 'h40;
        i2c_start();
        exp_q.push_back('{wr: 1'b0, addr: 8'h40, data: 8'h00});
        send_byte(8'hA1, a); chk("dev_ack_r", 32'(a), 32'd0);
        for (int i = 0; i < 3; i++) bit_cycle(1'b1, s);
        scl_m = 1'b0; wclk(12);
        chk("oe_before_rst", 32'(oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("oe_after_rst", 32'(oe), 32'd0);
        chk("busy_after_rst", 32'(busy), 32'd0);
        chk("ptr_after_rst", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        ptr_m = 0;
        sda_m = 1'b1; wclk(8);
        scl_m = 1'b1; wclk(8);
        $display("[TB] reset mid-read done");
        txn_current_read(2);

        for (int t = 0; t < 14; t++) begin
            sel = int'($urandom_range(0, 3));
            n   = int'($urandom_range(1, 4));
            case (sel)
                0: begin
                    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
                    txn_write(8'($urandom), d, n);
                end
                1: txn_random_read(8'($urandom), n);
                2: txn_current_read(n);
                default: begin
                    dev = 8'($urandom);
                    if (dev[7:1] == 7'h50) dev = dev ^ 8'h02;
                    txn_mismatch(dev);
                end
            endcase
        end

        wclk(20);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
